// File: rtl/esplink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : esplink_pkg
// Description : Shared types and constants for the byte-stream to APB bridge:
//               FSM state encoding, response status codes and command-byte
//               field definitions.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package esplink_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WDATA  = 3'd2,
    ST_SETUP  = 3'd3,
    ST_ACCESS = 3'd4,
    ST_RESP   = 3'd5,
    ST_RDATA  = 3'd6
  } state_t;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_SLVERR  = 8'h01;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h02;
  localparam logic [7:0] STATUS_BADCMD  = 8'h03;

  localparam int         CMD_WRITE_BIT = 0;
  localparam logic [7:0] CMD_RSVD_MASK = 8'hFE;

  // Any reserved command bit set makes the command unusable.
  function automatic logic cmd_is_bad(input logic [7:0] cmd);
    return (cmd & CMD_RSVD_MASK) != 8'h00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/esplink_byte_shreg.sv
`default_nettype none
// ============================================================================
// Module      : esplink_byte_shreg
// Description : 32-bit register that collects or emits a word one byte at a
//               time, MSB first, with a 2-bit count of bytes moved.
// Ports       : clk, rstn      - clock, synchronous active-low reset
//               load           - parallel load of load_data, clears count
//               load_data[31:0]- word to load
//               shift_in       - shift in_byte into the LSB end
//               in_byte[7:0]   - byte to shift in
//               shift_out      - shift the word up one byte (MSB leaves)
//               word[31:0]     - current contents
//               count[1:0]     - bytes shifted since load/reset (wraps at 4)
// Revision    : 1.0 - initial release
// ============================================================================
module esplink_byte_shreg (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        shift_in,
  input  logic [7:0]  in_byte,
  input  logic        shift_out,
  output logic [31:0] word,
  output logic [1:0]  count
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      word  <= '0;
      count <= '0;
    end else if (load) begin
      word  <= load_data;
      count <= '0;
    end else if (shift_in) begin
      word  <= {word[23:0], in_byte};
      count <= count + 2'd1;
    end else if (shift_out) begin
      word  <= {word[23:0], 8'h00};
      count <= count + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/esplink_byte2apb.sv
`default_nettype none
// ============================================================================
// Module      : esplink_byte2apb
// Description : Byte-stream to APB master bridge. A request frame (command,
//               4 address bytes, 4 write-data bytes for writes) drives one
//               APB transfer; a status byte, plus 4 read-data bytes for
//               reads, is returned on the tx stream.
// Ports       : clk, rstn                - clock, synchronous active-low reset
//               rx_valid/rx_data/rx_ready - inbound byte stream
//               tx_valid/tx_data/tx_ready - outbound byte stream
//               psel/penable/pwrite/paddr/pwdata - APB master request
//               pready/pslverr/prdata     - APB slave response
// Revision    : 1.0 - initial release
// ============================================================================
module esplink_byte2apb #(
  parameter int APB_AW  = 32,
  parameter int APB_DW  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [APB_AW-1:0] paddr,
  output logic [APB_DW-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [APB_DW-1:0] prdata
);

  import esplink_pkg::*;

  localparam int            CW       = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  state_t        state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    tx_data_nxt;
  logic          is_write, is_write_nxt;
  logic          bad, bad_nxt;

  logic          rx_fire, tx_fire;
  logic          addr_shift;
  logic          data_shift_in, data_shift_out, data_load;
  logic [31:0]   data_load_val;
  logic [31:0]   addr_word, data_word;
  logic [1:0]    addr_cnt, data_cnt;

  assign rx_fire = rx_valid & rx_ready;
  assign tx_fire = tx_valid & tx_ready;

  esplink_byte_shreg u_addr (
    .clk       (clk),
    .rstn      (rstn),
    .load      (1'b0),
    .load_data (32'h0),
    .shift_in  (addr_shift),
    .in_byte   (rx_data),
    .shift_out (1'b0),
    .word      (addr_word),
    .count     (addr_cnt)
  );

  // Collects write data, then later holds captured read data for output.
  esplink_byte_shreg u_data (
    .clk       (clk),
    .rstn      (rstn),
    .load      (data_load),
    .load_data (data_load_val),
    .shift_in  (data_shift_in),
    .in_byte   (rx_data),
    .shift_out (data_shift_out),
    .word      (data_word),
    .count     (data_cnt)
  );

  // Both shift registers are frozen between SETUP and the end of ACCESS,
  // so driving the APB address/data straight from them keeps them stable.
  assign paddr  = APB_AW'(addr_word);
  assign pwdata = APB_DW'(data_word);

  always_comb begin
    nxt            = state;
    cnt_nxt        = cnt;
    tx_data_nxt    = tx_data;
    is_write_nxt   = is_write;
    bad_nxt        = bad;
    addr_shift     = 1'b0;
    data_shift_in  = 1'b0;
    data_shift_out = 1'b0;
    data_load      = 1'b0;
    data_load_val  = '0;
    case (state)
      ST_IDLE: begin
        if (rx_fire) begin
          if (cmd_is_bad(rx_data)) begin
            nxt         = ST_RESP;
            bad_nxt     = 1'b1;
            tx_data_nxt = STATUS_BADCMD;
          end else begin
            nxt          = ST_ADDR;
            bad_nxt      = 1'b0;
            is_write_nxt = rx_data[CMD_WRITE_BIT];
          end
        end
      end
      ST_ADDR: begin
        if (rx_fire) begin
          addr_shift = 1'b1;
          if (addr_cnt == 2'd3) begin
            nxt     = is_write ? ST_WDATA : ST_SETUP;
            cnt_nxt = '0;
          end
        end
      end
      ST_WDATA: begin
        if (rx_fire) begin
          data_shift_in = 1'b1;
          if (data_cnt == 2'd3) begin
            nxt     = ST_SETUP;
            cnt_nxt = '0;
          end
        end
      end
      ST_SETUP: begin
        nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          nxt         = ST_RESP;
          tx_data_nxt = pslverr ? STATUS_SLVERR : STATUS_OK;
          if (!is_write) begin
            data_load     = 1'b1;
            data_load_val = 32'(prdata);
          end
        end else if (cnt == CNT_LAST) begin
          // Last allowed ACCESS cycle without pready: abort, read data zero.
          nxt         = ST_RESP;
          tx_data_nxt = STATUS_TIMEOUT;
          if (!is_write) begin
            data_load     = 1'b1;
            data_load_val = '0;
          end
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_RESP: begin
        if (tx_fire) begin
          if (!is_write && !bad) begin
            nxt            = ST_RDATA;
            data_shift_out = 1'b1;
            tx_data_nxt    = data_word[31:24];
          end else begin
            nxt = ST_IDLE;
          end
        end
      end
      ST_RDATA: begin
        // The count returns to 0 once the 4th byte has been staged on tx_data,
        // so the handshake of that byte ends the frame.
        if (tx_fire) begin
          if (data_cnt == 2'd0) begin
            nxt = ST_IDLE;
          end else begin
            data_shift_out = 1'b1;
            tx_data_nxt    = data_word[31:24];
          end
        end
      end
      default: begin
        nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      is_write <= 1'b0;
      bad      <= 1'b0;
      rx_ready <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
    end else begin
      state    <= nxt;
      cnt      <= cnt_nxt;
      is_write <= is_write_nxt;
      bad      <= bad_nxt;
      tx_data  <= tx_data_nxt;
      rx_ready <= (nxt == ST_IDLE) || (nxt == ST_ADDR) || (nxt == ST_WDATA);
      tx_valid <= (nxt == ST_RESP) || (nxt == ST_RDATA);
      psel     <= (nxt == ST_SETUP) || (nxt == ST_ACCESS);
      penable  <= (nxt == ST_ACCESS);
      if ((state != ST_SETUP) && (nxt == ST_SETUP)) begin
        pwrite <= is_write;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_esplink_byte2apb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_esplink_byte2apb
// Description : Self-checking bench for esplink_byte2apb. Expected tx bytes
//               and APB transfers are queued when a frame is driven and are
//               popped as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_esplink_byte2apb;

  logic        clk      = 1'b0;
  logic        rstn     = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        pready   = 1'b0;
  logic        pslverr  = 1'b0;
  logic [31:0] prdata   = 32'h0;

  always #5 clk = ~clk;

  esplink_byte2apb #(.APB_AW(32), .APB_DW(32), .TIMEOUT(255)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .prdata   (prdata)
  );

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } apb_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  txq[$];
  apb_t        apbq[$];

  // Slave behaviour for the current transaction.
  int          ready_at   = 1;      // ACCESS cycle that sees pready; 0 = never
  logic        slverr_cfg = 1'b0;
  logic [31:0] rdata_cfg  = 32'h0;
  int          bp_mode    = 0;      // 0 always ready, 1 toggling, 2 random

  int          acc_cyc   = 0;
  int          setup_run = 0;
  bit          psel_seen = 1'b0;
  logic [31:0] s_addr = 32'h0, s_wdata = 32'h0;
  logic        s_write = 1'b0;
  apb_t        ea;

  bit          stall_pending = 1'b0;
  logic [7:0]  stall_data    = 8'h00;
  logic [7:0]  exp_b;

  // ---------------- tx consumer / scoreboard ----------------
  always @(negedge clk) begin
    if (!rstn) begin
      stall_pending = 1'b0;
      tx_ready      = 1'b0;
    end else begin
      if (stall_pending) begin
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== stall_data) begin
          n_fail++;
          $display("FAIL tx_stable: tx_valid=%b tx_data=%h, required 1/%h", tx_valid, tx_data, stall_data);
        end
      end
      case (bp_mode)
        1:       tx_ready = ~tx_ready;
        2:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b1;
      endcase
      if (tx_valid && tx_ready) begin
        n_tests++;
        if (txq.size() == 0) begin
          n_fail++;
          $display("FAIL tx_unexpected: got byte %h, required none", tx_data);
        end else begin
          exp_b = txq.pop_front();
          if (tx_data !== exp_b) begin
            n_fail++;
            $display("FAIL tx_byte: got %h, required %h", tx_data, exp_b);
          end
        end
      end
      stall_pending = tx_valid && !tx_ready;
      stall_data    = tx_data;
    end
  end

  // ---------------- APB slave / monitor ----------------
  always @(negedge clk) begin
    if (!rstn) begin
      pready    = 1'b0;
      pslverr   = 1'b0;
      setup_run = 0;
    end else if (psel && !penable) begin
      psel_seen = 1'b1;
      setup_run++;
      acc_cyc = 0;
      s_addr  = paddr;
      s_write = pwrite;
      s_wdata = pwdata;
      pready  = 1'b0;
      pslverr = 1'b0;
    end else if (psel && penable) begin
      psel_seen = 1'b1;
      acc_cyc++;
      if (acc_cyc == 1) begin
        n_tests++;
        if (setup_run != 1) begin
          n_fail++;
          $display("FAIL setup_len: SETUP lasted %0d cycles, required 1", setup_run);
        end
        setup_run = 0;
      end
      n_tests++;
      if (paddr !== s_addr || pwrite !== s_write || pwdata !== s_wdata) begin
        n_fail++;
        $display("FAIL apb_stable: paddr=%h pwrite=%b pwdata=%h, required %h/%b/%h",
                 paddr, pwrite, pwdata, s_addr, s_write, s_wdata);
      end
      pready  = (ready_at > 0) && (acc_cyc >= ready_at);
      pslverr = pready && slverr_cfg;
      prdata  = pready ? rdata_cfg : 32'hDEADBEEF;
      if (pready) begin
        n_tests++;
        if (apbq.size() == 0) begin
          n_fail++;
          $display("FAIL apb_unexpected: paddr=%h pwrite=%b, required no transfer", paddr, pwrite);
        end else begin
          ea = apbq.pop_front();
          if (pwrite !== ea.w || paddr !== ea.a || (ea.w && pwdata !== ea.d)) begin
            n_fail++;
            $display("FAIL apb_xfer: pwrite=%b paddr=%h pwdata=%h, required %b/%h/%h",
                     pwrite, paddr, pwdata, ea.w, ea.a, ea.d);
          end
        end
      end
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (t >= 600) begin
      n_tests++;
      n_fail++;
      $display("FAIL rx_accept: byte %h not taken, rx_ready=%b, required 1", b, rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic w, input logic [31:0] a, input logic [31:0] d);
    send_byte({7'b0, w});
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    if (w) for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask

  task automatic push_read_resp(input logic [7:0] st, input logic [31:0] d);
    txq.push_back(st);
    for (int i = 3; i >= 0; i--) txq.push_back(d[i*8 +: 8]);
  endtask

  task automatic wait_done(input string name, input int budget);
    int t = 0;
    while ((txq.size() != 0 || apbq.size() != 0 || rx_ready !== 1'b1 || tx_valid !== 1'b0)
           && t < budget) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (t >= budget) begin
      n_fail++;
      $display("FAIL %s_done: txq=%0d apbq=%0d rx_ready=%b tx_valid=%b, required 0/0/1/0",
               name, txq.size(), apbq.size(), rx_ready, tx_valid);
      txq.delete();
      apbq.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({psel, penable, pwrite} !== 3'b000 || paddr !== 32'h0 || pwdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_apb: psel/penable/pwrite=%b%b%b paddr=%h pwdata=%h, required all 0",
               psel, penable, pwrite, paddr, pwdata);
    end
    n_tests++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_tx: tx_valid=%b tx_data=%h, required 0/00", tx_valid, tx_data);
    end
    n_tests++;
    if (rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rx_ready: got %b, required 0", rx_ready);
    end
    rstn = 1'b1;
    @(negedge clk);
    n_tests++;
    if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rx_ready=%b tx_valid=%b, required 1/0", rx_ready, tx_valid);
    end
  endtask

  task automatic test_write();
    bp_mode = 0; ready_at = 1; slverr_cfg = 1'b0;
    apbq.push_back(apb_t'{w: 1'b1, a: 32'h0, d: 32'h1});
    txq.push_back(8'h00);
    send_frame(1'b1, 32'h0, 32'h1);
    n_tests++;
    if (psel !== 1'b1 || penable !== 1'b0) begin
      n_fail++;
      $display("FAIL write_setup_latency: psel=%b penable=%b, required 1/0", psel, penable);
    end
    @(negedge clk);
    n_tests++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      n_fail++;
      $display("FAIL write_access_latency: psel=%b penable=%b, required 1/1", psel, penable);
    end
    @(negedge clk);
    n_tests++;
    if (tx_valid !== 1'b1 || psel !== 1'b0 || penable !== 1'b0) begin
      n_fail++;
      $display("FAIL write_resp_latency: tx_valid=%b psel=%b penable=%b, required 1/0/0",
               tx_valid, psel, penable);
    end
    wait_done("write", 1000);
  endtask

  task automatic test_read_backpressure();
    bp_mode = 1; ready_at = 1; rdata_cfg = 32'h0000_0001;
    apbq.push_back(apb_t'{w: 1'b0, a: 32'h4, d: 32'h0});
    push_read_resp(8'h00, 32'h0000_0001);
    send_frame(1'b0, 32'h4, 32'h0);
    wait_done("read_bp", 1000);
    bp_mode = 0;
  endtask

  task automatic test_timeout();
    bp_mode = 0; ready_at = 0; rdata_cfg = 32'hFFFF_FFFF;
    push_read_resp(8'h02, 32'h0);
    send_frame(1'b0, 32'h20, 32'h0);
    wait_done("timeout", 1000);
    n_tests++;
    if (acc_cyc != 255) begin
      n_fail++;
      $display("FAIL timeout_len: ACCESS lasted %0d cycles, required 255", acc_cyc);
    end
    ready_at = 1;
  endtask

  task automatic test_slverr();
    ready_at = 3; slverr_cfg = 1'b1;
    apbq.push_back(apb_t'{w: 1'b1, a: 32'h100, d: 32'hCAFE_F00D});
    txq.push_back(8'h01);
    send_frame(1'b1, 32'h100, 32'hCAFE_F00D);
    wait_done("slverr", 1000);
    n_tests++;
    if (acc_cyc != 3) begin
      n_fail++;
      $display("FAIL slverr_penable_len: penable high %0d cycles, required 3", acc_cyc);
    end
    slverr_cfg = 1'b0; ready_at = 1;
  endtask

  task automatic test_badcmd();
    psel_seen = 1'b0;
    txq.push_back(8'h03);
    send_byte(8'h80);
    n_tests++;
    if (rx_ready !== 1'b0 || tx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL badcmd_resp_state: rx_ready=%b tx_valid=%b, required 0/1", rx_ready, tx_valid);
    end
    wait_done("badcmd", 200);
    n_tests++;
    if (psel_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL badcmd_psel: psel asserted=%b, required 0", psel_seen);
    end
    // Second bad command immediately followed by a valid read frame.
    rdata_cfg = 32'hA1B2_C3D4;
    txq.push_back(8'h03);
    apbq.push_back(apb_t'{w: 1'b0, a: 32'h10, d: 32'h0});
    push_read_resp(8'h00, 32'hA1B2_C3D4);
    send_byte(8'h81);
    send_frame(1'b0, 32'h10, 32'h0);
    wait_done("badcmd_next", 1000);
  endtask

  task automatic test_reset_mid_access();
    int t = 0;
    ready_at = 0;
    send_frame(1'b0, 32'h44, 32'h0);
    while (!(psel === 1'b1 && penable === 1'b1) && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (t >= 20) begin
      n_fail++;
      $display("FAIL rstmid_access: ACCESS not reached, psel=%b penable=%b, required 1/1", psel, penable);
    end
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({psel, penable, tx_valid, rx_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_outputs: psel/penable/tx_valid/rx_ready=%b%b%b%b, required 0000",
               psel, penable, tx_valid, rx_ready);
    end
    rstn = 1'b1;
    @(negedge clk);
    n_tests++;
    if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_release: rx_ready=%b tx_valid=%b, required 1/0", rx_ready, tx_valid);
    end
    repeat (3) @(negedge clk);
    ready_at = 1;
    apbq.push_back(apb_t'{w: 1'b1, a: 32'h8, d: 32'h55AA_55AA});
    txq.push_back(8'h00);
    send_frame(1'b1, 32'h8, 32'h55AA_55AA);
    wait_done("rstmid_write", 1000);
  endtask

  task automatic test_back_to_back();
    logic        w;
    logic [31:0] a, d;
    bp_mode = 2;
    for (int k = 0; k < 6; k++) begin
      w         = 1'($urandom_range(0, 1));
      a         = $urandom;
      d         = $urandom;
      ready_at  = $urandom_range(1, 4);
      rdata_cfg = $urandom;
      apbq.push_back(apb_t'{w: w, a: a, d: d});
      if (w) txq.push_back(8'h00);
      else   push_read_resp(8'h00, rdata_cfg);
      send_frame(w, a, d);
      wait_done("b2b", 1000);
    end
    bp_mode = 0; ready_at = 1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_write();
    test_read_backpressure();
    test_timeout();
    test_slverr();
    test_badcmd();
    test_reset_mid_access();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/esplink_byte2apb.md
ESPLINK_BYTE2APB -- requirements
Module: esplink_byte2apb

Interface
REQ-001 The block SHALL take parameter APB_AW, default 32, meaning APB address width.
REQ-002 The block SHALL take parameter APB_DW, default 32, meaning APB data width; only 32 is supported.
REQ-003 The block SHALL take parameter TIMEOUT, default 255, meaning the maximum number of ACCESS cycles to wait for pready.
REQ-004 Ports SHALL be as follows, clock and reset first:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- rx_valid  in  1  inbound byte valid
- rx_data  in  8  inbound byte
- rx_ready  out  1  inbound byte accepted
- tx_valid  out  1  outbound byte valid
- tx_data  out  8  outbound byte
- tx_ready  in  1  outbound byte consumed
- psel, penable, pwrite  out  1 each  APB master control
- paddr  out  APB_AW  APB address
- pwdata  out  APB_DW  APB write data
- pready, pslverr  in  1 each  APB slave response
- prdata  in  APB_DW  APB read data

Function
REQ-005 A byte SHALL transfer on rx, and likewise on tx, in any cycle where valid and ready are both high.
REQ-006 Request frame SHALL be: one command byte, then 4 address bytes MSB-first, then 4 data bytes MSB-first (write only).
- Command bit0 = 1 means write, 0 means read.
- Command bits 7:1 nonzero is an invalid command.
REQ-007 The FSM SHALL have states IDLE, ADDR, WDATA, SETUP, ACCESS, RESP, RDATA.
REQ-008 rx_ready SHALL be 1 only in IDLE, ADDR and WDATA; tx_valid SHALL be 1 only in RESP and RDATA.
REQ-009 State transitions SHALL be:
- IDLE -> ADDR on a valid command.
- IDLE -> RESP with status 0x03 on an invalid command; no APB access; no further rx bytes consumed for that frame.
- ADDR -> WDATA (write) or SETUP (read) after the 4th address byte.
- WDATA -> SETUP after the 4th data byte.
REQ-010 SETUP SHALL last exactly one cycle with psel=1 and penable=0; paddr, pwrite and pwdata SHALL be stable from SETUP until ACCESS exits.
REQ-011 ACCESS SHALL hold psel=1 and penable=1 until pready=1, then go to RESP on the next cycle with psel=0 and penable=0.
REQ-012 On completion, status SHALL be 0x01 if pslverr=1, else 0x00; prdata SHALL be captured in the cycle pready=1.
REQ-013 If TIMEOUT ACCESS cycles elapse without pready, the block SHALL abort: drop psel/penable next cycle, status 0x02, read data 0x00000000.
REQ-014 The timeout counter SHALL be ceil(log2(TIMEOUT+1)) bits, cleared on SETUP entry, and SHALL never wrap.
REQ-015 RESP SHALL send the status byte; RESP SHALL then go to RDATA for reads with a valid command, else to IDLE.
REQ-016 RDATA SHALL send 4 bytes of captured read data MSB-first, then go to IDLE.
REQ-017 tx_data SHALL hold stable while tx_valid=1 and tx_ready=0.
REQ-018 Minimum latency SHALL be: last request byte accepted at cycle N -> SETUP at N+1 -> ACCESS at N+2 -> with pready=1 at N+2, tx_valid=1 at N+3.
REQ-019 The block SHALL handle one transaction at a time; there is no pipelining.

Reset
REQ-020 While rstn=0 on a clk edge, the FSM SHALL enter IDLE and all outputs SHALL reset to 0: psel, penable, pwrite, paddr, pwdata, tx_valid, tx_data, rx_ready.
REQ-021 Reset SHALL override any in-progress frame or APB access; the partial frame is discarded and no response is sent.
REQ-022 rx_ready SHALL be 0 during the reset cycle and 1 in the first cycle after rstn rises.

Structure
REQ-023 Package esplink_pkg SHALL hold:
- the state enum;
- status codes OK=0x00, SLVERR=0x01, TIMEOUT=0x02, BADCMD=0x03;
- command bit positions and the reserved mask 0xFE.
REQ-024 Sub-module esplink_byte_shreg (a 32-bit byte shift register with load, shift-in and shift-out, plus a 2-bit byte counter) SHALL be instantiated twice:
- one instance for address;
- one instance for data, shared for write collection and read serialization.

Verification
REQ-025 Write: rx 0x01, 00 00 00 00, 00 00 00 01, pready=1 -> one APB write, paddr=0x0, pwdata=0x1, SETUP one cycle, tx 0x00.
REQ-026 Read with backpressure: rx 0x00, 00 00 00 04, prdata=0x00000001, pready=1, tx_ready toggling -> tx 0x00,0x00,0x00,0x00,0x01 with tx_data stable while stalled.
REQ-027 Timeout: read with pready held 0 -> psel drops after exactly 255 ACCESS cycles, tx 0x02 then 00 00 00 00.
REQ-028 Slave error: write with pslverr=1 and pready=1 on the 3rd ACCESS cycle -> tx 0x01, penable high for exactly 3 cycles.
REQ-029 Bad command: rx 0x80 -> tx 0x03, psel never asserted, next byte treated as a new command.
REQ-030 Reset mid-access: rstn=0 during ACCESS -> psel=0 next edge, no tx byte, and a following write completes normally.
